// File: rtl/ysyx_22050368_pipe_ctrl_if.sv
// Redirect/stall request bundle between the pipeline stages and the pipeline control unit.
// The master side raises requests; the slave side (pipe_ctrl) returns the PC/pipeline controls.
interface ysyx_22050368_pipe_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              ex_jump_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              ex_hold_i;
    logic              int_req_i;
    logic [ADDR_W-1:0] int_addr_i;
    logic              ifu_busy_i;
    logic              lsu_busy_i;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic [2:0]        hold_flag_o;
    logic              int_ack_o;

    modport master (
        output ex_jump_i, ex_jump_addr_i, ex_hold_i, int_req_i, int_addr_i,
               ifu_busy_i, lsu_busy_i,
        input  jump_flag_o, jump_addr_o, hold_flag_o, int_ack_o
    );

    modport slave (
        input  ex_jump_i, ex_jump_addr_i, ex_hold_i, int_req_i, int_addr_i,
               ifu_busy_i, lsu_busy_i,
        output jump_flag_o, jump_addr_o, hold_flag_o, int_ack_o
    );
endinterface

// File: rtl/ysyx_22050368_pipe_ctrl.sv
// Pipeline control: merges execute/interrupt redirects with stall sources and defers
// any redirect that arrives under an outstanding instruction fetch until the fetch completes.
module ysyx_22050368_pipe_ctrl #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22050368_pipe_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]           stall_cnt_o
);
    localparam logic [0:0] RUN        = 1'b0;
    localparam logic [0:0] WAIT_FETCH = 1'b1;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    logic [0:0]        st_q, st_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_int_q, pend_int_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              int_elig;
    logic [2:0]        hold_lvl;
    logic              eff_valid;
    logic              eff_int;
    logic [ADDR_W-1:0] eff_addr;
    logic              issue;

    always_comb begin
        int_elig = bus.int_req_i & ~bus.lsu_busy_i & ~bus.ex_hold_i;

        if (bus.lsu_busy_i || bus.ex_hold_i || (st_q == WAIT_FETCH)) begin
            hold_lvl = HOLD_ID;
        end else if (bus.ifu_busy_i) begin
            hold_lvl = HOLD_IF;
        end else begin
            hold_lvl = HOLD_NONE;
        end

        // In WAIT_FETCH the pending slot is first updated by any overriding source, so the
        // redirect issued when the fetch drops already reflects same-cycle arrivals.
        eff_valid = 1'b0;
        eff_int   = 1'b0;
        eff_addr  = '0;
        if (st_q == RUN) begin
            eff_valid = int_elig | bus.ex_jump_i;
            eff_int   = int_elig;
            if (int_elig) begin
                eff_addr = bus.int_addr_i;
            end else if (bus.ex_jump_i) begin
                eff_addr = bus.ex_jump_addr_i;
            end
        end else begin
            eff_valid = 1'b1;
            eff_int   = pend_int_q;
            eff_addr  = pend_addr_q;
            if (!pend_int_q) begin
                if (int_elig) begin
                    eff_int  = 1'b1;
                    eff_addr = bus.int_addr_i;
                end else if (bus.ex_jump_i) begin
                    eff_addr = bus.ex_jump_addr_i;
                end
            end
        end

        issue = eff_valid & ~bus.ifu_busy_i & ~rst;

        bus.jump_flag_o = issue;
        bus.jump_addr_o = issue ? eff_addr : '0;
        bus.int_ack_o   = issue & eff_int;
        bus.hold_flag_o = rst ? HOLD_NONE : hold_lvl;
        stall_cnt_o     = rst ? '0 : stall_cnt_q;

        if (eff_valid && bus.ifu_busy_i) begin
            st_d        = WAIT_FETCH;
            pend_addr_d = eff_addr;
            pend_int_d  = eff_int;
        end else begin
            st_d        = RUN;
            pend_addr_d = pend_addr_q;
            pend_int_d  = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if ((hold_lvl != HOLD_NONE) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= RUN;
            pend_addr_q <= '0;
            pend_int_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            st_q        <= st_d;
            pend_addr_q <= pend_addr_d;
            pend_int_q  <= pend_int_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050368_pipe_ctrl.sv
// Directed bench for ysyx_22050368_pipe_ctrl: inputs change on the falling edge and the
// combinational outputs are sampled 1ns later, well away from the rising edge.
module tb_ysyx_22050368_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;
    logic [3:0]  sat_cnt;
    int          total = 0;
    int          bad   = 0;

    ysyx_22050368_pipe_ctrl_if #(.ADDR_W(64)) bif ();
    ysyx_22050368_pipe_ctrl_if #(.ADDR_W(64)) sif ();

    ysyx_22050368_pipe_ctrl #(.ADDR_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave), .stall_cnt_o(stall_cnt)
    );

    ysyx_22050368_pipe_ctrl #(.ADDR_W(64), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(sif.slave), .stall_cnt_o(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bif.ex_jump_i = 1'b0; bif.ex_jump_addr_i = '0; bif.ex_hold_i = 1'b0;
        bif.int_req_i = 1'b0; bif.int_addr_i = '0;
        bif.ifu_busy_i = 1'b0; bif.lsu_busy_i = 1'b0;
    endtask

    task automatic test_reset();
        sif.ex_jump_i = 1'b0; sif.ex_jump_addr_i = '0; sif.ex_hold_i = 1'b0;
        sif.int_req_i = 1'b0; sif.int_addr_i = '0;
        sif.ifu_busy_i = 1'b0; sif.lsu_busy_i = 1'b0;
        rst = 1'b1;
        bif.ex_jump_i = 1'b1; bif.ex_jump_addr_i = 64'h8000_0010; bif.ex_hold_i = 1'b1;
        bif.int_req_i = 1'b1; bif.int_addr_i = 64'h8000_0020;
        bif.ifu_busy_i = 1'b1; bif.lsu_busy_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            total++;
            if (bif.jump_flag_o !== 1'b0 || bif.jump_addr_o !== 64'h0 || bif.hold_flag_o !== 3'd0
                || bif.int_ack_o !== 1'b0 || stall_cnt !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got flag=%b addr=%h hold=%0d ack=%b cnt=%0d exp all 0",
                         i, bif.jump_flag_o, bif.jump_addr_o, bif.hold_flag_o, bif.int_ack_o, stall_cnt);
            end
        end
        cyc();
        rst = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (stall_cnt !== 32'd0 || bif.hold_flag_o !== 3'd0 || bif.jump_flag_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got cnt=%0d hold=%0d flag=%b exp 0 0 0",
                     stall_cnt, bif.hold_flag_o, bif.jump_flag_o);
        end
    endtask

    task automatic test_direct_jump();
        cyc();
        bif.ex_jump_i = 1'b1; bif.ex_jump_addr_i = 64'h8000_0100;
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b1 || bif.jump_addr_o !== 64'h8000_0100 || bif.int_ack_o !== 1'b0
            || bif.hold_flag_o !== 3'd0) begin
            bad++;
            $display("FAIL direct_issue got flag=%b addr=%h ack=%b hold=%0d exp 1 80000100 0 0",
                     bif.jump_flag_o, bif.jump_addr_o, bif.int_ack_o, bif.hold_flag_o);
        end
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b0 || bif.jump_addr_o !== 64'h0) begin
            bad++;
            $display("FAIL direct_after got flag=%b addr=%h exp 0 0", bif.jump_flag_o, bif.jump_addr_o);
        end
    endtask

    task automatic test_deferred_jump();
        logic [2:0] exp_hold [3];
        exp_hold[0] = 3'd2; exp_hold[1] = 3'd3; exp_hold[2] = 3'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            bif.ifu_busy_i = 1'b1;
            bif.ex_jump_i = (i == 0); bif.ex_jump_addr_i = (i == 0) ? 64'h8000_0200 : 64'h0;
            #1;
            total++;
            if (bif.jump_flag_o !== 1'b0 || bif.hold_flag_o !== exp_hold[i]) begin
                bad++;
                $display("FAIL deferred_wait cyc=%0d got flag=%b hold=%0d exp 0 %0d",
                         i, bif.jump_flag_o, bif.hold_flag_o, exp_hold[i]);
            end
        end
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b1 || bif.jump_addr_o !== 64'h8000_0200 || bif.int_ack_o !== 1'b0
            || stall_cnt !== 32'd3) begin
            bad++;
            $display("FAIL deferred_issue got flag=%b addr=%h ack=%b cnt=%0d exp 1 80000200 0 3",
                     bif.jump_flag_o, bif.jump_addr_o, bif.int_ack_o, stall_cnt);
        end
        cyc(); #1;
        total++;
        if (bif.jump_flag_o !== 1'b0 || bif.hold_flag_o !== 3'd0 || stall_cnt !== 32'd4) begin
            bad++;
            $display("FAIL deferred_after got flag=%b hold=%0d cnt=%0d exp 0 0 4",
                     bif.jump_flag_o, bif.hold_flag_o, stall_cnt);
        end
    endtask

    task automatic test_int_vs_jump();
        cyc();
        bif.int_req_i = 1'b1; bif.int_addr_i = 64'h8000_0004;
        bif.ex_jump_i = 1'b1; bif.ex_jump_addr_i = 64'h8000_0300;
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b1 || bif.jump_addr_o !== 64'h8000_0004 || bif.int_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL int_vs_jump got flag=%b addr=%h ack=%b exp 1 80000004 1",
                     bif.jump_flag_o, bif.jump_addr_o, bif.int_ack_o);
        end
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b0 || bif.int_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL int_vs_jump_after got flag=%b ack=%b exp 0 0", bif.jump_flag_o, bif.int_ack_o);
        end
    endtask

    task automatic test_int_gating();
        for (int i = 0; i < 4; i++) begin
            cyc();
            bif.int_req_i = 1'b1; bif.int_addr_i = 64'h8000_0008; bif.lsu_busy_i = 1'b1;
            #1;
            total++;
            if (bif.int_ack_o !== 1'b0 || bif.jump_flag_o !== 1'b0 || bif.hold_flag_o !== 3'd3) begin
                bad++;
                $display("FAIL int_gated cyc=%0d got ack=%b flag=%b hold=%0d exp 0 0 3",
                         i, bif.int_ack_o, bif.jump_flag_o, bif.hold_flag_o);
            end
        end
        cyc();
        bif.lsu_busy_i = 1'b0;
        #1;
        total++;
        if (bif.int_ack_o !== 1'b1 || bif.jump_flag_o !== 1'b1 || bif.jump_addr_o !== 64'h8000_0008
            || stall_cnt !== 32'd8) begin
            bad++;
            $display("FAIL int_released got ack=%b flag=%b addr=%h cnt=%0d exp 1 1 80000008 8",
                     bif.int_ack_o, bif.jump_flag_o, bif.jump_addr_o, stall_cnt);
        end
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bif.int_ack_o !== 1'b0 || bif.jump_flag_o !== 1'b0) begin
            bad++;
            $display("FAIL int_released_after got ack=%b flag=%b exp 0 0", bif.int_ack_o, bif.jump_flag_o);
        end
    endtask

    task automatic test_deferred_int();
        for (int i = 0; i < 2; i++) begin
            cyc();
            bif.int_req_i = 1'b1; bif.int_addr_i = 64'h8000_000c; bif.ifu_busy_i = 1'b1;
            #1;
            total++;
            if (bif.int_ack_o !== 1'b0 || bif.jump_flag_o !== 1'b0
                || bif.hold_flag_o !== ((i == 0) ? 3'd2 : 3'd3)) begin
                bad++;
                $display("FAIL defint_wait cyc=%0d got ack=%b flag=%b hold=%0d exp 0 0 %0d",
                         i, bif.int_ack_o, bif.jump_flag_o, bif.hold_flag_o, (i == 0) ? 2 : 3);
            end
        end
        cyc();
        bif.ifu_busy_i = 1'b0;
        #1;
        total++;
        if (bif.int_ack_o !== 1'b1 || bif.jump_flag_o !== 1'b1 || bif.jump_addr_o !== 64'h8000_000c) begin
            bad++;
            $display("FAIL defint_issue got ack=%b flag=%b addr=%h exp 1 1 8000000c",
                     bif.int_ack_o, bif.jump_flag_o, bif.jump_addr_o);
        end
        cyc();
        idle_inputs();
        #1;
        total++;
        if (bif.int_ack_o !== 1'b0 || bif.jump_flag_o !== 1'b0) begin
            bad++;
            $display("FAIL defint_after got ack=%b flag=%b exp 0 0", bif.int_ack_o, bif.jump_flag_o);
        end
    endtask

    task automatic test_wait_reset();
        cyc();
        bif.ex_jump_i = 1'b1; bif.ex_jump_addr_i = 64'h8000_0400; bif.ifu_busy_i = 1'b1;
        cyc();
        bif.ex_jump_i = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b0 || bif.hold_flag_o !== 3'd0 || stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wait_reset_forced got flag=%b hold=%0d cnt=%0d exp 0 0 0",
                     bif.jump_flag_o, bif.hold_flag_o, stall_cnt);
        end
        cyc();
        rst = 1'b0; bif.ifu_busy_i = 1'b0;
        #1;
        total++;
        if (bif.jump_flag_o !== 1'b0 || bif.jump_addr_o !== 64'h0 || bif.hold_flag_o !== 3'd0
            || stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wait_reset_dropped got flag=%b addr=%h hold=%0d cnt=%0d exp 0 0 0 0",
                     bif.jump_flag_o, bif.jump_addr_o, bif.hold_flag_o, stall_cnt);
        end
        cyc(); #1;
        total++;
        if (bif.jump_flag_o !== 1'b0) begin
            bad++;
            $display("FAIL wait_reset_late got flag=%b exp 0", bif.jump_flag_o);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            cyc();
            sif.lsu_busy_i = 1'b1;
            #1;
            if (i == 10) begin
                total++;
                if (sat_cnt !== 4'd10) begin
                    bad++;
                    $display("FAIL sat_midway got cnt=%0d exp 10", sat_cnt);
                end
            end
        end
        cyc();
        sif.lsu_busy_i = 1'b0;
        #1;
        total++;
        if (sat_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_final got cnt=%0d exp 15", sat_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_direct_jump();
        test_deferred_jump();
        test_int_vs_jump();
        test_int_gating();
        test_deferred_int();
        test_wait_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
